// File: rtl/bmem_burst_ctrl_pkg.sv
// Shared sizing and state/owner types for the burst memory controller.
package bmem_burst_ctrl_pkg;

    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned LINE_W    = 256;
    localparam int unsigned BEAT_W    = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        DONE
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

endpackage

// File: rtl/bmem_burst_ctrl_line_buffer.sv
// Line register holding one cache line as beats; whole-line load, per-beat write and read.
module burst_line_buffer
    import bmem_burst_ctrl_pkg::*;
#(
    parameter int unsigned NumBeats = BURST_LEN,
    parameter int unsigned IdxW     = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic [NumBeats*BEAT_W-1:0] load_line_i,
    input  logic                       wr_en_i,
    input  logic [IdxW-1:0]            wr_idx_i,
    input  logic [BEAT_W-1:0]          wr_beat_i,
    input  logic [IdxW-1:0]            rd_idx_i,
    output logic [BEAT_W-1:0]          rd_beat_o,
    output logic [NumBeats*BEAT_W-1:0] line_o
);

    logic [BEAT_W-1:0] beat_q [NumBeats];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumBeats; i++) begin
                beat_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < NumBeats; i++) begin
                beat_q[i] <= load_line_i[i*BEAT_W +: BEAT_W];
            end
        end else if (wr_en_i) begin
            beat_q[wr_idx_i] <= wr_beat_i;
        end
    end

    assign rd_beat_o = beat_q[rd_idx_i];

    // Beat 0 occupies the least significant bits of the line.
    always_comb begin
        line_o = '0;
        for (int i = 0; i < NumBeats; i++) begin
            line_o[i*BEAT_W +: BEAT_W] = beat_q[i];
        end
    end

endmodule

// File: rtl/bmem_burst_ctrl.sv
// Arbitrates icache/dcache line requests onto a 64-bit burst memory port,
// assembling read bursts into lines and serialising writeback lines into beats.
module bmem_burst_ctrl #(
    parameter int unsigned BURST_LEN  = bmem_burst_ctrl_pkg::BURST_LEN,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_dfp_addr,
    input  logic         i_dfp_read,
    output logic [255:0] i_dfp_rdata,
    output logic         i_dfp_resp,
    input  logic [31:0]  d_dfp_addr,
    input  logic         d_dfp_read,
    input  logic         d_dfp_write,
    input  logic [255:0] d_dfp_wdata,
    output logic [255:0] d_dfp_rdata,
    output logic         d_dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);
    import bmem_burst_ctrl_pkg::*;

    localparam int unsigned CntW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [StarveW-1:0] starve_q, starve_d;
    owner_e             owner_q, owner_d;
    logic               wr_op_q, wr_op_d;
    logic [31:0]        addr_q, addr_d;

    logic           buf_load, buf_wr;
    logic [63:0]    buf_rd_beat;
    logic [255:0]   buf_line;
    logic           d_req, starve_max, grant_i, grant_d, last_beat;

    // Read beats are matched by order only, so the return address is not needed.
    logic unused_raddr;
    assign unused_raddr = ^bmem_raddr;

    assign d_req      = d_dfp_read | d_dfp_write;
    assign starve_max = (starve_q == StarveW'(STARVE_MAX));
    assign grant_i    = (state_q == IDLE) & i_dfp_read & (~d_req | starve_max);
    assign grant_d    = (state_q == IDLE) & d_req & ~grant_i;
    assign last_beat  = (cnt_q == CntW'(BURST_LEN - 1));

    burst_line_buffer #(
        .NumBeats (BURST_LEN),
        .IdxW     (CntW)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (buf_load),
        .load_line_i (d_dfp_wdata),
        .wr_en_i     (buf_wr),
        .wr_idx_i    (cnt_q),
        .wr_beat_i   (bmem_rdata),
        .rd_idx_i    (cnt_q),
        .rd_beat_o   (buf_rd_beat),
        .line_o      (buf_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            owner_q  <= OWN_I;
            wr_op_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            wr_op_q  <= wr_op_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        wr_op_d     = wr_op_q;
        addr_d      = addr_q;
        buf_load    = 1'b0;
        buf_wr      = 1'b0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_addr   = '0;
        bmem_wdata  = '0;
        i_dfp_resp  = 1'b0;
        d_dfp_resp  = 1'b0;
        i_dfp_rdata = '0;
        d_dfp_rdata = '0;

        // Starvation only accumulates while I is actually waiting behind D.
        if (!i_dfp_read || grant_i) begin
            starve_d = '0;
        end else if (grant_d && !starve_max) begin
            starve_d = starve_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    owner_d  = grant_i ? OWN_I : OWN_D;
                    wr_op_d  = grant_d & d_dfp_write;
                    addr_d   = {(grant_i ? i_dfp_addr[31:5] : d_dfp_addr[31:5]), 5'b0};
                    buf_load = 1'b1;
                    state_d  = (grant_d && d_dfp_write) ? WR_BURST : RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid) begin
                    buf_wr = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = buf_rd_beat;
                if (bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (owner_q == OWN_I) begin
                    i_dfp_resp  = 1'b1;
                    i_dfp_rdata = wr_op_q ? '0 : buf_line;
                end else begin
                    d_dfp_resp  = 1'b1;
                    d_dfp_rdata = wr_op_q ? '0 : buf_line;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bmem_burst_ctrl.sv
// Directed bench for bmem_burst_ctrl: reads, writes, stalls, arbitration and reset abort.
module tb_bmem_burst_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_dfp_addr;
    logic         i_dfp_read;
    logic [255:0] i_dfp_rdata;
    logic         i_dfp_resp;
    logic [31:0]  d_dfp_addr;
    logic         d_dfp_read;
    logic         d_dfp_write;
    logic [255:0] d_dfp_wdata;
    logic [255:0] d_dfp_rdata;
    logic         d_dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int checks   = 0;
    int failures = 0;

    logic [255:0] line1, line2, line3, wline, wline2, wline3;
    int unsigned  stall_beat [7] = '{0, 1, 2, 2, 2, 2, 3};
    bit           stall_rdy  [7] = '{1, 1, 0, 0, 0, 1, 1};
    bit           exp_i      [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit           ok;

    bmem_burst_ctrl #(
        .BURST_LEN  (4),
        .STARVE_MAX (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_bmem_read"}, bmem_read, 0);
        chk({tag, "_bmem_write"}, bmem_write, 0);
        chk({tag, "_bmem_addr"}, bmem_addr, 0);
        chk({tag, "_bmem_wdata"}, bmem_wdata, 0);
        chk({tag, "_i_resp"}, i_dfp_resp, 0);
        chk({tag, "_d_resp"}, d_dfp_resp, 0);
        chk({tag, "_i_rdata"}, i_dfp_rdata, 0);
        chk({tag, "_d_rdata"}, d_dfp_rdata, 0);
    endtask

    // Drive n consecutive read beats taken from line, then leave the return bus idle.
    task automatic send_beats(input logic [255:0] line, input int n);
        for (int k = 0; k < n; k++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = line[k*64 +: 64];
            bmem_raddr  = 32'hdead_0000 + 32'(k);
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
    endtask

    task automatic wait_read(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bmem_read === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        line1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line2  = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                  64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        line3  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        wline  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        wline2 = {64'h0000_0000_0000_00B3, 64'h0000_0000_0000_00B2,
                  64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00B0};
        wline3 = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                  64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};

        rst = 1'b1;
        i_dfp_addr = '0; i_dfp_read = 1'b0;
        d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        bmem_ready = 1'b1;
        @(negedge clk);

        // icache read; address low bits must be cleared
        i_dfp_addr = 32'h0000_1024;
        i_dfp_read = 1'b1;
        @(negedge clk);
        chk("t1_bmem_read", bmem_read, 1);
        chk("t1_bmem_addr", bmem_addr, 32'h0000_1020);
        chk("t1_bmem_write", bmem_write, 0);
        @(negedge clk);
        chk("t1_read_released", bmem_read, 0);
        send_beats(line1, 4);
        chk("t1_i_resp", i_dfp_resp, 1);
        chk("t1_i_rdata", i_dfp_rdata, line1);
        chk("t1_d_resp", d_dfp_resp, 0);
        i_dfp_read = 1'b0;
        @(negedge clk);
        chk("t1_i_resp_pulse", i_dfp_resp, 0);
        chk("t1_i_rdata_cleared", i_dfp_rdata, 0);

        // dcache writeback, memory always ready: beats at T+1..T+4, resp at T+5
        d_dfp_addr  = 32'h8000_0040;
        d_dfp_write = 1'b1;
        d_dfp_wdata = wline;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("t2_bmem_write", bmem_write, 1);
            chk("t2_bmem_addr", bmem_addr, 32'h8000_0040);
            chk("t2_bmem_wdata", bmem_wdata, wline[k*64 +: 64]);
            if (k == 0) d_dfp_wdata = '1;
            @(negedge clk);
        end
        chk("t2_d_resp", d_dfp_resp, 1);
        chk("t2_d_rdata_zero", d_dfp_rdata, 0);
        chk("t2_write_released", bmem_write, 0);
        chk("t2_i_resp", i_dfp_resp, 0);
        d_dfp_write = 1'b0;
        @(negedge clk);
        chk("t2_d_resp_pulse", d_dfp_resp, 0);

        // writeback with bmem_ready low for three cycles on beat 2
        d_dfp_addr  = 32'h0000_0040;
        d_dfp_write = 1'b1;
        d_dfp_wdata = wline2;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            chk("t3_bmem_write", bmem_write, 1);
            chk("t3_bmem_wdata", bmem_wdata, wline2[stall_beat[k]*64 +: 64]);
            bmem_ready = stall_rdy[k];
            @(negedge clk);
        end
        chk("t3_d_resp", d_dfp_resp, 1);
        chk("t3_write_released", bmem_write, 0);
        d_dfp_write = 1'b0;
        bmem_ready  = 1'b1;
        @(negedge clk);

        // read and write both asserted: writeback wins
        d_dfp_addr  = 32'h0000_0100;
        d_dfp_read  = 1'b1;
        d_dfp_write = 1'b1;
        d_dfp_wdata = wline3;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("t4_bmem_write", bmem_write, 1);
            chk("t4_no_bmem_read", bmem_read, 0);
            chk("t4_bmem_wdata", bmem_wdata, wline3[k*64 +: 64]);
            @(negedge clk);
        end
        chk("t4_d_resp", d_dfp_resp, 1);
        chk("t4_d_rdata_zero", d_dfp_rdata, 0);
        d_dfp_read  = 1'b0;
        d_dfp_write = 1'b0;
        @(negedge clk);

        // both caches held: D,D,D,I,D,D,D,I
        i_dfp_addr = 32'h0000_1000;
        d_dfp_addr = 32'h0000_2000;
        i_dfp_read = 1'b1;
        d_dfp_read = 1'b1;
        for (int g = 0; g < 8; g++) begin
            wait_read(ok);
            chk("t5_grant_seen", ok, 1);
            chk("t5_grant_addr", bmem_addr, exp_i[g] ? 32'h0000_1000 : 32'h0000_2000);
            @(negedge clk);
            send_beats(line1, 4);
            chk("t5_i_resp", i_dfp_resp, exp_i[g]);
            chk("t5_d_resp", d_dfp_resp, !exp_i[g]);
            if (g == 7) begin
                i_dfp_read = 1'b0;
                d_dfp_read = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check_quiet("t5_idle");

        // reset after two read beats aborts; late beats ignored; next read is clean
        i_dfp_addr = 32'h0000_3000;
        i_dfp_read = 1'b1;
        @(negedge clk);
        chk("t6_bmem_read", bmem_read, 1);
        @(negedge clk);
        send_beats(line2, 2);
        rst         = 1'b1;
        i_dfp_read  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_rdata  = line2[2*64 +: 64];
        @(negedge clk);
        check_quiet("t6_rst");
        rst        = 1'b0;
        bmem_rdata = line2[3*64 +: 64];
        @(negedge clk);
        check_quiet("t6_late_beat");
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        chk("t6_no_resp", i_dfp_resp, 0);
        i_dfp_addr = 32'h0000_4000;
        i_dfp_read = 1'b1;
        @(negedge clk);
        chk("t6_new_addr", bmem_addr, 32'h0000_4000);
        @(negedge clk);
        send_beats(line3, 4);
        chk("t6_new_resp", i_dfp_resp, 1);
        chk("t6_new_rdata", i_dfp_rdata, line3);
        i_dfp_read = 1'b0;
        @(negedge clk);
        chk("t6_resp_pulse", i_dfp_resp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
